// File: rtl/lbist_prpg_misr.sv
// Logic-BIST engine: a single LFSR that runs either as a pseudo-random pattern
// generator or as a multiple-input signature register, for a programmed number of cycles.
module lbist_prpg_misr #(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [N-1:0]     seed,
    input  logic [N-1:0]     taps,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [N-1:0]     resp_in,
    output logic [N-1:0]     pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0]     REG_ONE = N'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [N-1:0]     r_q;
    logic [N-1:0]     taps_q;
    logic [N-1:0]     sig_q;
    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] num_q;
    logic             busy_q;
    logic             done_q;
    logic             pv_q;

    logic [N-1:0]     load_d;
    logic [N-1:0]     r_d;
    logic             last_d;

    function automatic logic parity_f(input logic [N-1:0] v);
        parity_f = ^v;
    endfunction

    // Load value, next LFSR/MISR state and final-cycle detect.
    always_comb begin
        load_d = seed;
        r_d    = {parity_f(r_q & taps_q), r_q[N-1:1]};
        last_d = 1'b0;
        // An all-zero PRPG seed would lock the LFSR at zero forever.
        if (!mode && (seed == '0)) begin
            load_d = REG_ONE;
        end else begin
            load_d = seed;
        end
        if (mode_q) begin
            r_d = {parity_f(r_q & taps_q), r_q[N-1:1]} ^ resp_in;
        end else begin
            r_d = {parity_f(r_q & taps_q), r_q[N-1:1]};
        end
        last_d = (cnt_q == (num_q - CNT_ONE));
    end

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            taps_q  <= '0;
            sig_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            num_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        taps_q <= taps;
                        num_q  <= num_patterns;
                        r_q    <= load_d;
                        cnt_q  <= '0;
                        if (num_patterns == '0) begin
                            state_q <= DONE;
                            sig_q   <= load_d;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            pv_q    <= ~mode;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // Abort takes priority over a coinciding final cycle.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pv_q    <= 1'b0;
                    end else begin
                        r_q   <= r_d;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (last_d) begin
                            state_q <= DONE;
                            sig_q   <= r_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pv_q    <= 1'b0;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pv_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pattern       = r_q;
    assign pattern_valid = pv_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign signature     = sig_q;

endmodule

// File: tb/tb_lbist_prpg_misr.sv
// Directed and randomized checks of lbist_prpg_misr (N=4) against an
// arithmetic LFSR/MISR reference model.
module tb_lbist_prpg_misr;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode;
    logic [3:0]  seed;
    logic [3:0]  taps;
    logic [15:0] num_patterns;
    logic [3:0]  resp_in;
    logic [3:0]  pattern;
    logic        pattern_valid;
    logic        busy;
    logic        done;
    logic [3:0]  signature;

    int          tests = 0;
    int          fails = 0;
    logic [3:0]  last_sig = 4'h0;
    logic [3:0]  exp_pat[$];

    lbist_prpg_misr #(.N(4), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .mode          (mode),
        .seed          (seed),
        .taps          (taps),
        .num_patterns  (num_patterns),
        .resp_in       (resp_in),
        .pattern       (pattern),
        .pattern_valid (pattern_valid),
        .busy          (busy),
        .done          (done),
        .signature     (signature)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: shift right, parity of tapped bits enters at the MSB, response XORed in MISR mode.
    function automatic logic [3:0] model_step(input logic [3:0] r, input logic [3:0] tp,
                                              input logic m, input logic [3:0] resp);
        int fb;
        int v;
        fb = $countones(r & tp) % 2;
        v  = int'(r) / 2 + fb * 8;
        if (m) v = v ^ int'(resp);
        return v[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run from IDLE; called 1 time unit after a clock edge.
    task automatic do_run(input logic m, input logic [3:0] sd, input logic [3:0] tp,
                          input int np, input bit rnd_resp, input logic [3:0] resp,
                          input bit hold_start);
        logic [3:0] r;
        r            = (!m && sd == 4'h0) ? 4'h1 : sd;
        mode         = m;
        seed         = sd;
        taps         = tp;
        num_patterns = 16'(np);
        start        = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        mode         = 1'($urandom);
        seed         = 4'($urandom);
        taps         = 4'($urandom);
        num_patterns = 16'($urandom_range(0, 40));
        for (int i = 0; i < np; i++) begin
            chk("busy_run", busy, 1'b1);
            chk("done_run", done, 1'b0);
            chk("pattern", pattern, r);
            chk("pvalid", pattern_valid, !m);
            chk("sig_hold_run", signature, last_sig);
            if (exp_pat.size() > 0) chk("pattern_table", pattern, exp_pat.pop_front());
            resp_in = rnd_resp ? 4'($urandom) : resp;
            r = model_step(r, tp, m, resp_in);
            tick();
        end
        start = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("signature", signature, r);
        last_sig = r;
        tick();
        chk("done_low", done, 1'b0);
        chk("idle_hold", pattern, r);
        chk("idle_pvalid", pattern_valid, 1'b0);
    endtask

    initial begin
        logic [3:0] r;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        seed = 4'h0; taps = 4'h0; num_patterns = 16'd0; resp_in = 4'h0;
        tick();
        tick();
        chk("rst_pattern", pattern, 4'h0);
        chk("rst_pvalid", pattern_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sig", signature, 4'h0);
        reset = 1'b0;
        tick();

        // Maximal-length PRPG sequence with the listed pattern table.
        exp_pat = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                    4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
        do_run(1'b0, 4'h8, 4'h3, 15, 1'b0, 4'h0, 1'b0);
        chk("prpg15_sig", signature, 4'h8);
        chk("prpg15_table_used", exp_pat.size(), 0);

        // MISR compaction of a constant response.
        do_run(1'b1, 4'h0, 4'h3, 2, 1'b0, 4'h1, 1'b0);
        chk("misr2_sig", signature, 4'h9);

        // Zero PRPG seed is replaced by 1.
        exp_pat = '{4'h1, 4'h8};
        do_run(1'b0, 4'h0, 4'h3, 2, 1'b0, 4'h0, 1'b0);

        // Zero-length run.
        do_run(1'b0, 4'h5, 4'h3, 0, 1'b0, 4'h0, 1'b0);
        chk("np0_sig", signature, 4'h5);

        // Abort in the third RUN cycle of a 10-pattern run.
        mode = 1'b0; seed = 4'h6; taps = 4'h9; num_patterns = 16'd10; start = 1'b1;
        r = 4'h6;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_busy", busy, 1'b1);
            chk("abort_pattern", pattern, r);
            r = model_step(r, 4'h9, 1'b0, 4'h0);
            if (i == 2) abort = 1'b1;
            else tick();
        end
        tick();
        abort = 1'b0;
        chk("abort_busy_off", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_pvalid", pattern_valid, 1'b0);
        chk("abort_sig", signature, last_sig);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle", busy, 1'b0);
        end
        do_run(1'b0, 4'h6, 4'h9, 10, 1'b0, 4'h0, 1'b0);

        // Reset pulse in the middle of a run.
        mode = 1'b1; seed = 4'h9; taps = 4'h3; num_patterns = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        resp_in = 4'h7;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pattern", pattern, 4'h0);
        chk("mid_rst_pvalid", pattern_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_sig", signature, 4'h0);
        tick();
        reset = 1'b0;
        last_sig = 4'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end

        // start held high throughout a run has no effect until completion.
        do_run(1'b0, 4'hB, 4'hC, 5, 1'b0, 4'h0, 1'b1);

        // Randomized runs in both modes.
        for (int k = 0; k < 12; k++) begin
            do_run(1'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 20),
                   1'b1, 4'h0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lbist_prpg_misr.md
LBIST_PRPG_MISR -- requirements
Module: lbist_prpg_misr

Interface
REQ-001 SHALL have parameter N, default 16: LFSR/MISR register width, legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default 16: pattern-counter width.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  terminate run, sampled in RUN only.
REQ-007 SHALL have port mode  input  1  0 = PRPG (pattern generation), 1 = MISR (response compaction); captured at start.
REQ-008 SHALL have port seed  input  N  initial register value; captured at start.
REQ-009 SHALL have port taps  input  N  feedback mask, bit i set = r[i] in feedback; captured at start.
REQ-010 SHALL have port num_patterns  input  CNT_W  number of RUN cycles; captured at start.
REQ-011 SHALL have port resp_in  input  N  circuit response, XORed in during MISR RUN cycles.
REQ-012 SHALL have port pattern  output  N  current register value.
REQ-013 SHALL have port pattern_valid  output  1  high in every RUN cycle when the captured mode is PRPG.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-016 SHALL have port signature  output  N  final register value, held until the next start.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 IDLE with start=1 SHALL capture mode, taps and num_patterns, load the register and clear the counter. Next state SHALL be RUN, or DONE if num_patterns==0.
REQ-019 Register load SHALL be seed, except that PRPG with seed==0 SHALL load 1 to prevent lockup.
REQ-020 Feedback SHALL be fb = XOR-reduce(r & taps_captured); taps==0 gives fb=0 and is legal.
REQ-021 Each PRPG RUN cycle SHALL update r <= {fb, r[N-1:1]}.
REQ-022 Each MISR RUN cycle SHALL update r <= {fb, r[N-1:1]} ^ resp_in.
REQ-023 In RUN, pattern SHALL equal the pre-update r; pattern_valid SHALL be 1 in PRPG mode and 0 in MISR mode.
REQ-024 The counter SHALL increment each RUN cycle; the cycle with count==num_patterns-1 SHALL transition to DONE after its update.
REQ-025 Latency: if start is sampled at edge k, the first RUN cycle SHALL follow edge k and done SHALL be high for the single cycle after edge k+num_patterns (after edge k when num_patterns==0).
REQ-026 On entering DONE, signature SHALL be loaded with r; done=1 for exactly one cycle; next state SHALL be IDLE.
REQ-027 start SHALL be ignored in RUN and DONE; ports seed, taps, num_patterns and mode SHALL have no effect outside the start-capture cycle.
REQ-028 abort=1 in RUN SHALL return the FSM to IDLE on the next edge; the abort SHALL have no done pulse and signature SHALL remain unchanged.
REQ-029 If abort and the final RUN cycle coincide, abort SHALL win (no done pulse, no signature update).
REQ-030 In IDLE, the register SHALL hold and pattern SHALL show the held value.
REQ-031 The counter SHALL not wrap: num_patterns = 2^CNT_W-1 is the maximum run length.

Reset
REQ-032 reset SHALL asynchronously force IDLE, with register, counter, captured taps/mode and signature cleared to 0.
REQ-033 After reset, outputs SHALL be pattern=0, pattern_valid=0, busy=0, done=0 and signature=0.
REQ-034 reset asserted mid-RUN SHALL abandon the run immediately with no done pulse.

Verification
REQ-035 Bench SHALL cover: N=4, taps=0011, seed=1000, PRPG, num_patterns=15 -> patterns 1000,0100,0010,1001,1100,0110,1011,0101,1010,1101,1110,1111,0111,0011,0001; done one cycle later; signature=1000.
REQ-036 Bench SHALL cover: N=4, taps=0011, seed=0000, MISR, resp_in=0001 for 2 cycles, num_patterns=2 -> pattern_valid stays 0; signature=1001; done 2 cycles after start capture.
REQ-037 Bench SHALL cover: PRPG with seed=0 -> first pattern=0001 (N=4, taps=0011), second pattern=1000.
REQ-038 Bench SHALL cover: num_patterns=0 with seed=0101 -> busy never high; done on the cycle after start; signature=0101.
REQ-039 Bench SHALL cover: abort in the third RUN cycle of a 10-pattern run -> IDLE next cycle; done stays 0; signature keeps its previous value. Then restart -> full 10-pattern run completes normally.
REQ-040 Bench SHALL cover: reset pulse mid-RUN -> all outputs 0 within the same cycle; start held high during RUN (no reset) -> no restart until after DONE.
